// File: rtl/imem_responder_pkg.sv
// Shared types and constants for the instruction-memory responder.
package imem_responder_pkg;

    localparam int WORD_BITS = 32;
    localparam int CNT_BITS  = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP,
        GAP
    } state_e;

endpackage

// File: rtl/imem_array.sv
// Word-wide synchronous RAM, one write port and one read port.
module imem_array
    import imem_responder_pkg::*;
#(
    parameter int WORDS = 1024,
    parameter int AW    = 10
) (
    input  logic                 clk,
    input  logic                 we_i,
    input  logic [AW-1:0]        waddr_i,
    input  logic [WORD_BITS-1:0] wdata_i,
    input  logic                 re_i,
    input  logic [AW-1:0]        raddr_i,
    output logic [WORD_BITS-1:0] rdata_o
);

    logic [WORD_BITS-1:0] mem_q [WORDS];
    logic [WORD_BITS-1:0] rdata_q;

    // Both ports sample the old contents, so a same-edge collision reads old data.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/imem_responder.sv
// Fixed-latency instruction fetch responder backed by a preloadable array.
module imem_responder
    import imem_responder_pkg::*;
#(
    parameter int MEM_WORDS = 1024,
    parameter int LATENCY   = 2
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 mem_req_valid,
    input  logic [31:0]          mem_req_addr,
    output logic                 mem_req_ready,
    output logic [WORD_BITS-1:0] mem_req_rdata,
    input  logic                 load_en,
    input  logic [31:0]          load_addr,
    input  logic [WORD_BITS-1:0] load_data,
    output logic                 err_oob,
    output logic [31:0]          req_count
);

    localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [29:0] LIMIT = 30'(MEM_WORDS);
    localparam logic [CNT_BITS-1:0] CNT_INIT = CNT_BITS'(LATENCY - 1);

    state_e               state_q;
    logic [CNT_BITS-1:0]  cnt_q;
    logic [AW-1:0]        idx_q;
    logic                 oob_q;
    logic                 ready_q;
    logic [WORD_BITS-1:0] rdata_q;
    logic [31:0]          count_q;
    logic                 err_q;

    logic [29:0]          req_widx;
    logic [29:0]          ld_widx;
    logic                 req_oob;
    logic                 ld_oob;
    logic                 ld_we;
    logic                 rd_en;
    logic [WORD_BITS-1:0] arr_rdata;
    logic                 unused_byte_bits;

    assign req_widx = mem_req_addr[31:2];
    assign ld_widx  = load_addr[31:2];
    assign req_oob  = req_widx >= LIMIT;
    assign ld_oob   = ld_widx >= LIMIT;
    assign ld_we    = load_en && !ld_oob;
    assign unused_byte_bits = ^{mem_req_addr[1:0], load_addr[1:0]};

    assign rd_en = (state_q == WAIT) && mem_req_valid
                && (cnt_q == '0) && !oob_q;

    imem_array #(
        .WORDS (MEM_WORDS),
        .AW    (AW)
    ) u_array (
        .clk     (clk),
        .we_i    (ld_we),
        .waddr_i (ld_widx[AW-1:0]),
        .wdata_i (load_data),
        .re_i    (rd_en),
        .raddr_i (idx_q),
        .rdata_o (arr_rdata)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            oob_q   <= 1'b0;
            ready_q <= 1'b0;
            rdata_q <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            rdata_q <= '0;
            if (load_en && ld_oob) begin
                err_q <= 1'b1;
            end
            unique case (state_q)
                IDLE: begin
                    if (mem_req_valid) begin
                        idx_q   <= req_widx[AW-1:0];
                        oob_q   <= req_oob;
                        cnt_q   <= CNT_INIT;
                        state_q <= WAIT;
                        if (req_oob) begin
                            err_q <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (!mem_req_valid) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    ready_q <= 1'b1;
                    rdata_q <= oob_q ? '0 : arr_rdata;
                    count_q <= count_q + 32'd1;
                    state_q <= GAP;
                end
                GAP: begin
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_req_ready = ready_q;
    assign mem_req_rdata = rdata_q;
    assign req_count     = count_q;
    assign err_oob       = err_q;

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder with a cycle-level reference model.
module tb_imem_responder;

    localparam int LAT = 2;
    localparam int MW  = 1024;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        mem_req_valid = 1'b0;
    logic [31:0] mem_req_addr = '0;
    logic        mem_req_ready;
    logic [31:0] mem_req_rdata;
    logic        load_en = 1'b0;
    logic [31:0] load_addr = '0;
    logic [31:0] load_data = '0;
    logic        err_oob;
    logic [31:0] req_count;

    int n_cmp = 0;
    int n_err = 0;

    imem_responder #(
        .MEM_WORDS (MW),
        .LATENCY   (LAT)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .mem_req_valid (mem_req_valid),
        .mem_req_addr  (mem_req_addr),
        .mem_req_ready (mem_req_ready),
        .mem_req_rdata (mem_req_rdata),
        .load_en       (load_en),
        .load_addr     (load_addr),
        .load_data     (load_data),
        .err_oob       (err_oob),
        .req_count     (req_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, got, exp);
        end
    endtask

    // Reference model: a request is a timeline of edge numbers, not states.
    logic [31:0] mm [MW];
    int          cyc = 0;
    bit          busy = 0;
    int          acc = 0;
    int          free = 0;
    int unsigned m_idx = 0;
    bit          m_oob = 0;
    logic [31:0] snap = '0;
    logic        e_ready = 0;
    logic [31:0] e_rdata = '0;
    logic [31:0] e_cnt = '0;
    logic        e_err = 0;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            busy = 0; free = 0;
            e_ready = 0; e_rdata = '0; e_cnt = '0; e_err = 0;
        end else begin
            int unsigned w;
            cyc++;
            e_ready = 0;
            e_rdata = '0;
            if (busy) begin
                if (cyc == acc + LAT + 1) begin
                    e_ready = 1;
                    e_rdata = snap;
                    e_cnt = e_cnt + 1;
                    busy = 0;
                    free = cyc + 2;
                end else if (!mem_req_valid) begin
                    busy = 0;
                    free = cyc + 1;
                end else if (cyc == acc + LAT) begin
                    snap = m_oob ? 32'h0 : mm[m_idx];
                end
            end else if (cyc >= free && mem_req_valid) begin
                w = mem_req_addr >> 2;
                acc = cyc;
                m_oob = (w >= MW);
                m_idx = w;
                if (m_oob) e_err = 1;
                busy = 1;
            end
            if (load_en) begin
                w = load_addr >> 2;
                if (w < MW) mm[w] = load_data;
                else e_err = 1;
            end
        end
    end

    bit run = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (run) begin
                chk("cyc_ready", {31'h0, mem_req_ready}, {31'h0, e_ready});
                chk("cyc_rdata", mem_req_rdata, e_rdata);
                chk("cyc_count", req_count, e_cnt);
                chk("cyc_err", {31'h0, err_oob}, {31'h0, e_err});
            end
        end
    end

    task automatic load(input logic [31:0] a, input logic [31:0] d);
        load_en = 1'b1;
        load_addr = a;
        load_data = d;
        @(negedge clk);
        load_en = 1'b0;
    endtask

    task automatic wait_pulse(input int maxc, output int n,
                              output logic [31:0] d);
        n = 0;
        d = '0;
        forever begin
            @(negedge clk);
            n++;
            if (mem_req_ready) begin
                d = mem_req_rdata;
                break;
            end
            if (n >= maxc) begin
                chk("pulse_timeout", 32'(n), 32'(maxc + 1));
                break;
            end
        end
    endtask

    task automatic count_pulses(input int cycles, output int p);
        p = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (mem_req_ready) p++;
        end
    endtask

    initial begin
        int n;
        int p;
        logic [31:0] d;

        #1 resetn = 1'b0;
        @(negedge clk);
        run = 1;
        chk("rst_ready", {31'h0, mem_req_ready}, 32'h0);
        chk("rst_rdata", mem_req_rdata, 32'h0);
        chk("rst_count", req_count, 32'h0);
        chk("rst_err", {31'h0, err_oob}, 32'h0);
        @(negedge clk);
        resetn = 1'b1;

        load(32'h0, 32'h0000_0013);
        load(32'h4, 32'hDEAD_BEEF);
        load(32'h8, 32'h1111_1111);
        load(32'hC, 32'h3333_0003);
        @(negedge clk);

        // Basic read and held-valid reissue
        mem_req_valid = 1'b1;
        mem_req_addr = 32'h0;
        wait_pulse(10, n, d);
        chk("t1_lat", 32'(n), 32'd4);
        chk("t1_data", d, 32'h0000_0013);
        chk("t1_count", req_count, 32'd1);
        mem_req_addr = 32'h4;
        wait_pulse(12, n, d);
        chk("t2_spacing", 32'(n), 32'd5);
        chk("t2_data", d, 32'hDEAD_BEEF);
        chk("t2_count", req_count, 32'd2);
        mem_req_valid = 1'b0;
        @(negedge clk);

        // Abort one cycle after accept
        mem_req_valid = 1'b1;
        mem_req_addr = 32'h8;
        @(negedge clk);
        mem_req_valid = 1'b0;
        count_pulses(6, p);
        chk("t3_nopulse", 32'(p), 32'd0);
        chk("t3_count", req_count, 32'd2);
        mem_req_valid = 1'b1;
        mem_req_addr = 32'hC;
        wait_pulse(10, n, d);
        chk("t3_idle_lat", 32'(n), 32'd4);
        chk("t3_data", d, 32'h3333_0003);
        mem_req_valid = 1'b0;
        @(negedge clk);

        // Out-of-range request, then sticky error across a good one
        mem_req_valid = 1'b1;
        mem_req_addr = 32'h1000;
        wait_pulse(10, n, d);
        chk("t4_lat", 32'(n), 32'd4);
        chk("t4_data", d, 32'h0);
        chk("t4_err", {31'h0, err_oob}, 32'h1);
        mem_req_valid = 1'b0;
        @(negedge clk);
        mem_req_valid = 1'b1;
        mem_req_addr = 32'h7;
        wait_pulse(10, n, d);
        chk("t4_bytebits", d, 32'hDEAD_BEEF);
        chk("t4_sticky", {31'h0, err_oob}, 32'h1);
        mem_req_valid = 1'b0;
        @(negedge clk);

        // Load collides with the array read edge
        mem_req_valid = 1'b1;
        mem_req_addr = 32'h8;
        @(negedge clk);
        @(negedge clk);
        load_en = 1'b1;
        load_addr = 32'h8;
        load_data = 32'hCAFE_F00D;
        @(negedge clk);
        load_en = 1'b0;
        @(negedge clk);
        chk("t5_ready", {31'h0, mem_req_ready}, 32'h1);
        chk("t5_old", mem_req_rdata, 32'h1111_1111);
        mem_req_valid = 1'b0;
        @(negedge clk);
        mem_req_valid = 1'b1;
        wait_pulse(10, n, d);
        chk("t5_new", d, 32'hCAFE_F00D);
        chk("t5_count", req_count, 32'd7);
        mem_req_valid = 1'b0;
        @(negedge clk);

        // Reset in the middle of WAIT
        mem_req_valid = 1'b1;
        mem_req_addr = 32'h4;
        @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        chk("t6_ready", {31'h0, mem_req_ready}, 32'h0);
        chk("t6_count", req_count, 32'h0);
        chk("t6_err", {31'h0, err_oob}, 32'h0);
        mem_req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 resetn = 1'b1;
        count_pulses(6, p);
        chk("t6_nopulse", 32'(p), 32'd0);
        mem_req_valid = 1'b1;
        mem_req_addr = 32'h8;
        wait_pulse(10, n, d);
        chk("t6_lat", 32'(n), 32'd4);
        chk("t6_kept", d, 32'hCAFE_F00D);
        chk("t6_count1", req_count, 32'd1);
        mem_req_valid = 1'b0;
        @(negedge clk);

        // Out-of-range load
        load(32'h2000, 32'h5555_5555);
        chk("t7_ld_err", {31'h0, err_oob}, 32'h1);
        @(negedge clk);
        @(negedge clk);

        run = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/imem_responder.md
IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 Parameter MEM_WORDS, default 1024: backing-store depth in 32-bit words.
REQ-002 Parameter LATENCY, default 2, legal 1..15: cycles from request accept to mem_req_ready pulse.
REQ-003 clk  input  1  single clock; all logic on posedge.
REQ-004 resetn  input  1  reset, asynchronous, active-low.
REQ-005 mem_req_valid  input  1  read request from the fetch controller.
REQ-006 mem_req_addr  input  32  byte address; bits [1:0] ignored; word index = addr[31:2].
REQ-007 mem_req_ready  output  1  one-cycle pulse: mem_req_rdata valid this cycle.
REQ-008 mem_req_rdata  output  32  read data; 0 whenever mem_req_ready=0.
REQ-009 load_en  input  1  preload write strobe from the bench or dictionary loader.
REQ-010 load_addr  input  32  preload byte address; word-indexed like mem_req_addr.
REQ-011 load_data  input  32  preload data.
REQ-012 err_oob  output  1  sticky flag: a request or load targeted word index >= MEM_WORDS.
REQ-013 req_count  output  32  count of completed responses; wraps from 0xFFFFFFFF to 0.

Function
REQ-014 FSM states: IDLE, WAIT, RESP, GAP.
REQ-015 IDLE with mem_req_valid=1: capture word index, load latency counter with LATENCY-1, go to WAIT.
REQ-016 WAIT, counter != 0: decrement the counter.
REQ-017 WAIT, counter == 0: register array[captured index] into the read-data register, go to RESP.
REQ-018 RESP: mem_req_ready=1 and mem_req_rdata=registered data for exactly one cycle, increment req_count, go to GAP.
REQ-019 GAP: ignore mem_req_valid for one cycle, then go to IDLE, so a still-asserted valid is not re-accepted as a new request.
REQ-020 Latency: a request accepted at cycle t pulses mem_req_ready at cycle t+LATENCY+1.
REQ-021 Back-to-back: the earliest next accept is 2 cycles after the ready pulse.
REQ-022 mem_req_valid falls during WAIT: abort, go to IDLE, no ready pulse, req_count unchanged.
REQ-023 mem_req_addr changes during WAIT with valid high: ignored; the captured index is used.
REQ-024 Out-of-range request: completes with normal timing, returns rdata=0, sets err_oob.
REQ-025 load_en=1 with in-range index: array write on that edge in any state.
REQ-026 load_en=1 with out-of-range index: no write, sets err_oob.
REQ-027 Load to the same index in the same cycle as the WAIT->RESP read: the response returns the pre-load data, and the write still commits.
REQ-028 err_oob clears only on reset.

Reset
REQ-029 resetn=0 asynchronously forces: state=IDLE, mem_req_ready=0, mem_req_rdata=0, req_count=0, err_oob=0, latency counter=0.
REQ-030 Array contents are not reset; they hold their values across reset.
REQ-031 Reset asserted mid-WAIT or mid-RESP: the in-flight request is dropped and no ready pulse follows deassertion.
REQ-032 First request accept is allowed on the first posedge after resetn rises.

Structure
REQ-033 Shared package contains: the FSM state enum, the WORD_BITS=32 constant, and the latency-counter width constant (4 bits).
REQ-034 Storage is one sub-module, imem_array: synchronous single-write-port, single-read-port array with read-before-write on an address collision.
REQ-035 The FSM, counters, error logic and output muxing live in imem_responder.

Verification
REQ-036 Preload 0x00000013 at addr 0x0; request addr 0x0 with LATENCY=2 -> ready pulses 3 cycles after accept, rdata=0x00000013, req_count=1.
REQ-037 Hold valid high through ready and reissue addr 0x4 (preloaded 0xDEADBEEF) -> exactly one pulse for 0x0; the second pulse returns 0xDEADBEEF no earlier than 2 cycles after the first.
REQ-038 Drop valid one cycle after accept -> no ready pulse, req_count unchanged, FSM back in IDLE.
REQ-039 Request addr 0x1000 with MEM_WORDS=1024 -> ready pulse with rdata=0, err_oob=1, err_oob still 1 after a later good request.
REQ-040 Load 0xCAFEF00D to addr 0x8 on the WAIT->RESP cycle of a read of 0x8 holding 0x11111111 -> response 0x11111111; the next read returns 0xCAFEF00D.
REQ-041 Assert resetn=0 mid-WAIT -> outputs at reset values immediately, no pulse after release, previously loaded array data intact.
